// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU share arbiter: FSM state encoding and ALU control codes.
// The FSM is single-issue: IDLE grants, EXEC lets the ALU settle, RESP holds the result.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_JR  = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU signal bundle for the arbiter; slave = arbiter side,
// master = requesters plus the ALU instance.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CTR_W  = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [CTR_W-1:0]  req0_ctr;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [CTR_W-1:0]  req1_ctr;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_res;
    logic              rsp0_zero;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_res;
    logic              rsp1_zero;

    logic [DATA_W-1:0] alu_input1;
    logic [DATA_W-1:0] alu_input2;
    logic [CTR_W-1:0]  alu_ctr;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctr,
        input  req1_valid, req1_a, req1_b, req1_ctr,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_res, rsp0_zero,
        output rsp1_valid, rsp1_res, rsp1_zero,
        input  rsp0_ready, rsp1_ready,
        output alu_input1, alu_input2, alu_ctr,
        input  alu_res, alu_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctr,
        output req1_valid, req1_a, req1_b, req1_ctr,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_res, rsp0_zero,
        input  rsp1_valid, rsp1_res, rsp1_zero,
        output rsp0_ready, rsp1_ready,
        input  alu_input1, alu_input2, alu_ctr,
        output alu_res, alu_zero
    );

endinterface

// File: rtl/alu_share_arbiter_rr_picker.sv
// Two-way grant picker, purely combinational; last=1 means requester 1 won the
// previous grant, so requester 0 wins a tie. fixed_prio forces requester 0 on ties.
module alu_rr_picker (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    input  logic       fixed_prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = (fixed_prio || last) ? 2'b01 : 2'b10;
        end else begin
            grant = {valid1, valid0};
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters; accept->rsp_valid latency 2 cycles, one op in flight,
// result held until the owner takes it. ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTR_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus
);
    import alu_arb_pkg::*;

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] in1_q, in1_d;
    logic [DATA_W-1:0] in2_q, in2_d;
    logic [CTR_W-1:0]  ctr_q, ctr_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;

    logic [1:0]        gnt;
    logic [1:0]        req_rdy;
    logic [1:0]        rsp_vld;
    logic              rsp_take;
    logic              last_w;
    logic              fixed_prio_w;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign last_w       = 1'b1;
    assign fixed_prio_w = 1'b1;
`else
    logic last_q, last_d;

    assign last_w       = last_q;
    assign fixed_prio_w = 1'b0;

    // Pointer moves only when a request is actually accepted.
    always_comb begin
        last_d = last_q;
        if (|req_rdy) begin
            last_d = req_rdy[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    alu_rr_picker u_picker (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last       (last_w),
        .fixed_prio (fixed_prio_w),
        .grant      (gnt)
    );

    always_comb begin
        // Gated by reset so ready reads 0 the instant reset rises, even with valids held.
        req_rdy  = (state_q == IDLE && !reset) ? gnt : 2'b00;
        rsp_take = (state_q == RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
        state_d  = state_q;
        owner_d  = owner_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        ctr_d    = ctr_q;
        res_d    = res_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (|req_rdy) begin
                    state_d = EXEC;
                    owner_d = req_rdy[1];
                    in1_d   = req_rdy[1] ? bus.req1_a   : bus.req0_a;
                    in2_d   = req_rdy[1] ? bus.req1_b   : bus.req0_b;
                    ctr_d   = req_rdy[1] ? bus.req1_ctr : bus.req0_ctr;
                end
            end
            EXEC: begin
                state_d = RESP;
                res_d   = bus.alu_res;
                zero_d  = bus.alu_zero;
            end
            RESP: begin
                if (rsp_take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            in1_q   <= '0;
            in2_q   <= '0;
            ctr_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            ctr_q   <= ctr_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign rsp_vld[0] = (state_q == RESP) && !owner_q;
    assign rsp_vld[1] = (state_q == RESP) &&  owner_q;

    assign bus.req0_ready = req_rdy[0];
    assign bus.req1_ready = req_rdy[1];
    assign bus.rsp0_valid = rsp_vld[0];
    assign bus.rsp1_valid = rsp_vld[1];
    // Non-owner result lanes read zero rather than exposing the other requester's data.
    assign bus.rsp0_res   = rsp_vld[0] ? res_q  : '0;
    assign bus.rsp0_zero  = rsp_vld[0] ? zero_q : 1'b0;
    assign bus.rsp1_res   = rsp_vld[1] ? res_q  : '0;
    assign bus.rsp1_zero  = rsp_vld[1] ? zero_q : 1'b0;
    assign bus.alu_input1 = in1_q;
    assign bus.alu_input2 = in2_q;
    assign bus.alu_ctr    = ctr_q;

endmodule
